// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
//   Data-memory port between the M-stage access controller and the data
//   memory (or the bus bridge in front of it).
//
//   Request side (driven by the controller, modport master):
//     dmem_req    request valid, held until dmem_ready
//     dmem_we     1 = write, 0 = read
//     dmem_addr   doubleword-aligned address
//     dmem_wdata  store data already shifted into its byte lane
//     dmem_be     byte enables for the write
//   Response side (driven by the memory, modport slave):
//     dmem_ready  request accepted this cycle
//     dmem_rvalid read data valid (always after acceptance, never with it)
//     dmem_rdata  8-byte aligned doubleword
// -----------------------------------------------------------------------------
interface mem_stage_if #(
  parameter int XLEN = 64
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [7:0]      dmem_be;
  logic            dmem_ready;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   EX/MEM pipeline register plus data-memory access controller for the
//   RV64I-Zba 5-stage core. Captures the execute-stage results, performs
//   loads/stores over a req/ready + rvalid port with byte-lane alignment and
//   load sign/zero extension, and stalls the pipeline while an access is
//   outstanding.
//
//   Ports:
//     clk, rst_n           clock (rising edge), async active-low reset
//     ALUResult_E..funct3_E execute-stage results and control
//     ALUResult_M          registered ALU result (forwarding and WB)
//     Rd_M, RegWrite_M     registered destination / write enable
//                          (write enable dropped on a misaligned access)
//     MemRead_M            registered load flag (hazard unit, WB select)
//     ReadData_M           extended load data, valid while in DONE
//     Stall_M              freeze IF/ID/EX/M registers
//     Misaligned_M         current M op is a misaligned load/store
//     dmem                 data-memory port (mem_stage_if.master)
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] ALUResult_E,
  input  logic [XLEN-1:0] WriteData_E,
  input  logic [4:0]      Rd_E,
  input  logic            RegWrite_E,
  input  logic            MemRead_E,
  input  logic            MemWrite_E,
  input  logic [2:0]      funct3_E,
  output logic [XLEN-1:0] ALUResult_M,
  output logic [4:0]      Rd_M,
  output logic            RegWrite_M,
  output logic            MemRead_M,
  output logic [XLEN-1:0] ReadData_M,
  output logic            Stall_M,
  output logic            Misaligned_M,
  mem_stage_if.master     dmem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] read_data_q, read_data_d;

  logic            stall;
  logic            capture;
  logic            mem_op_e;
  logic            mis_e;
  logic [2:0]      off_m;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // size: 00=B, 01=H, 10=W, 11=D
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] off);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      2'b10:   mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

  function automatic logic [7:0] lane_be(input logic [1:0] size,
                                         input logic [2:0] off);
    logic [7:0] be;
    case (size)
      2'b00:   be = 8'h01 << off;
      2'b01:   be = 8'h03 << off;
      2'b10:   be = 8'h0F << off;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

  // Shift the addressed field down to bit 0, truncate to the access size and
  // extend. funct3[2] selects zero extension (LBU/LHU/LWU).
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                  input logic [2:0]      f3,
                                                  input logic [2:0]      off);
    logic [XLEN-1:0] field;
    logic [XLEN-1:0] res;
    logic            zext;
    field = rdata >> {off, 3'b000};
    zext  = f3[2];
    case (f3[1:0])
      2'b00:   res = zext ? {56'd0, field[7:0]}
                          : {{56{field[7]}}, field[7:0]};
      2'b01:   res = zext ? {48'd0, field[15:0]}
                          : {{48{field[15]}}, field[15:0]};
      2'b10:   res = zext ? {32'd0, field[31:0]}
                          : {{32{field[31]}}, field[31:0]};
      default: res = field;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stall is a pure decode of the registered state, so nothing from the
  // memory response reaches the upstream freeze combinationally.
  assign stall   = (state_q == REQ) || (state_q == WAIT);
  assign capture = !stall;

  assign mem_op_e = MemRead_E | MemWrite_E;
  assign mis_e    = mem_op_e & is_misaligned(funct3_E[1:0], ALUResult_E[2:0]);
  assign off_m    = alu_result_q[2:0];

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (capture) begin
      state_d = (mem_op_e && !mis_e) ? REQ : IDLE;
    end else begin
      case (state_q)
        // rvalid is never looked at here: a response always follows acceptance.
        REQ: begin
          if (dmem.dmem_ready) begin
            state_d = mem_write_q ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (dmem.dmem_rvalid) begin
            state_d = DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    dmem.dmem_req   = (state_q == REQ);
    dmem.dmem_we    = (state_q == REQ) & mem_write_q;
    dmem.dmem_be    = (state_q == REQ) ? lane_be(funct3_q[1:0], off_m) : 8'h00;
    dmem.dmem_addr  = {alu_result_q[XLEN-1:3], 3'b000};
    dmem.dmem_wdata = write_data_q << {off_m, 3'b000};
    Stall_M         = stall;
  end

  // ---------------------------------------------------------------------------
  // M register next values
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    funct3_d     = funct3_q;
    misaligned_d = misaligned_q;
    read_data_d  = read_data_q;

    if (capture) begin
      alu_result_d = ALUResult_E;
      write_data_d = WriteData_E;
      rd_d         = Rd_E;
      reg_write_d  = RegWrite_E & ~mis_e;
      mem_read_d   = MemRead_E;
      mem_write_d  = MemWrite_E;
      funct3_d     = funct3_E;
      misaligned_d = mis_e;
      read_data_d  = '0;
    end else if ((state_q == WAIT) && dmem.dmem_rvalid) begin
      read_data_d  = load_extend(dmem.dmem_rdata, funct3_q, off_m);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      funct3_q     <= '0;
      misaligned_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      funct3_q     <= funct3_d;
      misaligned_q <= misaligned_d;
      read_data_q  <= read_data_d;
    end
  end

  assign ALUResult_M  = alu_result_q;
  assign Rd_M         = rd_q;
  assign RegWrite_M   = reg_write_q;
  assign MemRead_M    = mem_read_q;
  assign ReadData_M   = read_data_q;
  assign Misaligned_M = misaligned_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- EX/MEM pipeline register plus data-memory access controller for the RV64I-Zba 5-stage core.
- Captures the execute-stage results: ALU result/address, store data, destination register and control.
- Performs RV64 loads and stores over a req/ready + rvalid data-memory port, with byte-lane alignment and load sign/zero extension.
- Stalls the pipeline while an access is outstanding. Feeds the MEM/WB register and the forwarding path (ALUResult_M).

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ALUResult_E  in  64  ALU result / effective address from execute
- WriteData_E  in  64  forwarded rs2 (store data)
- Rd_E  in  5  destination register
- RegWrite_E  in  1  register write enable
- MemRead_E  in  1  load instruction
- MemWrite_E  in  1  store instruction
- funct3_E  in  3  access size/signedness
- dmem_ready  in  1  memory accepts request this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  64  read data, 8-byte aligned doubleword
- ALUResult_M  out  64  registered ALU result (forwarding, WB)
- Rd_M  out  5  registered destination
- RegWrite_M  out  1  registered write enable; forced 0 on misaligned access
- MemRead_M  out  1  registered load flag (hazard unit, WB result select)
- ReadData_M  out  64  extended load data, valid while state=DONE
- Stall_M  out  1  freeze IF/ID/EX/M registers
- Misaligned_M  out  1  current M op is misaligned
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  64  {ALUResult_M[63:3], 3'b000}
- dmem_wdata  out  64  store data shifted to byte lane
- dmem_be  out  8  byte enables

Behaviour:
- Reset (async, rst_n=0): all M registers 0, state IDLE. All outputs 0: dmem_req, Stall_M, Misaligned_M, RegWrite_M, ReadData_M. Asserting reset mid-access drops dmem_req immediately. Any response arriving after reset is ignored.
- Capture: on a rising edge with Stall_M=0, all *_E inputs load into the M registers. With Stall_M=1, the M registers hold.
- Size, from funct3[1:0]: 00 = B, 01 = H, 10 = W, 11 = D. funct3[2]=1 means zero-extend (LBU/LHU/LWU); funct3 3'b111 is never issued.
- Alignment check on captured address bits [2:0]: H requires [0]=0, W requires [1:0]=0, D requires [2:0]=0.
- States: IDLE, REQ, WAIT, DONE. Next state at a capture edge:
  - aligned load/store captured -> REQ
  - misaligned load/store captured -> IDLE, Misaligned_M=1, RegWrite_M=0, no dmem_req
  - non-memory op captured -> IDLE
- REQ: dmem_req=1. dmem_we, dmem_addr, dmem_wdata and dmem_be stay stable until dmem_ready=1.
  - On ready, a store goes to DONE.
  - On ready, a load goes to WAIT. dmem_rvalid is never sampled in REQ.
- WAIT: dmem_req=0. On dmem_rvalid, the extracted data is latched into ReadData_M -> DONE.
- DONE: ReadData_M is held. The next capture edge leaves DONE.
- Stall_M = (state==REQ) | (state==WAIT). It is a registered-state decode with no combinational path from dmem_ready/rvalid.
- Minimum cycles in M with zero-wait memory: non-mem 1, store 2, load 3.
- Store lanes, with off = addr[2:0]:
  - dmem_wdata = WriteData_M << (8*off)
  - dmem_be: B = 1<<off, H = 3<<off, W = 8'h0F<<off, D = 8'hFF
- Load extract: field = dmem_rdata >> (8*off), truncated to size, then sign- or zero-extended to 64.
- Non-memory ops: ReadData_M = 0. ALUResult_M is valid every cycle regardless of state.
- Simultaneous dmem_ready and dmem_rvalid in REQ: rvalid is ignored, because a response always follows acceptance.
- A load followed by a dependent instruction is resolved by the hazard unit via MemRead_M/Rd_M. This block does not detect load-use hazards.

Test Plan:
- Reset mid-access: load accepted, rst_n low during WAIT -> dmem_req=0, Stall_M=0, state IDLE; the later rvalid is ignored and ReadData_M stays 0.
- Zero-wait load: LD, address 0x1000, ready=1 in first M cycle, rvalid=1 next cycle with rdata 0x8877665544332211 -> Stall_M high 2 cycles, ReadData_M=0x8877665544332211 in cycle 3.
- Sign/zero extension: rdata 0x00000000_80FF0000, address 0x2002. LH -> 0xFFFF_FFFF_FFFF_80FF. LHU -> 0x0000_0000_0000_80FF. LB at 0x2003 -> 0xFFFF_FFFF_FFFF_FF80.
- Store lanes: SB 0xAB at 0x3005 -> dmem_be=8'h20, dmem_wdata[47:40]=0xAB, dmem_addr=0x3000. SW at 0x3004 -> be=8'hF0.
- Wait states: SD with ready low 3 cycles -> req/addr/wdata/be stable for 4 cycles, Stall_M high 4 cycles, upstream ALUResult_E changes are not captured.
- Misaligned: LW at 0x4002 with RegWrite_E=1 -> no dmem_req, Misaligned_M=1, RegWrite_M=0, Stall_M=0; the next non-mem op captured the following edge.
